// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter with optional ownership lock, serialising requesters onto one mem port
// Ports: clk, rst (async, active-low); per-requester req_i/lock_i/we_i and packed addr_i/width_i/wdata_i
//        (requester 0 in the LSBs); ack_o one-hot completion pulse, rdata_o shared read data, busy_o;
//        mem_ce_o/mem_we_o/mem_addr_o/mem_width_o/mem_data_o single-cycle access, mem_data_i read data.
module mem_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         lock_i,
  input  logic [N_REQ-1:0]         we_i,
  input  logic [N_REQ*ADDR_W-1:0]  addr_i,
  input  logic [N_REQ*4-1:0]       width_i,
  input  logic [N_REQ*DATA_W-1:0]  wdata_i,
  output logic [N_REQ-1:0]         ack_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     busy_o,
  output logic                     mem_ce_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [3:0]               mem_width_o,
  output logic [DATA_W-1:0]        mem_data_o,
  input  logic [DATA_W-1:0]        mem_data_i
);
  localparam int IW = $clog2(N_REQ);
  localparam int LW = $clog2(MAX_LOCK) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state;
  logic [IW-1:0] win, last, owner, pick;
  logic owner_valid, hold, found;
  logic [LW-1:0] lock_cnt;
  // a live lock restricts the candidate set to the owner alone
  assign hold = owner_valid && lock_i[owner];
  // descending scan so the nearest index after last is assigned last and wins
  always_comb begin
    found = 1'b0;
    pick = owner;
    if (hold) found = req_i[owner];
    else
      for (int k = N_REQ; k >= 1; k--)
        if (req_i[IW'((int'(last) + k) % N_REQ)]) begin
          found = 1'b1;
          pick = IW'((int'(last) + k) % N_REQ);
        end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      win <= '0;
      last <= IW'(N_REQ - 1);
      owner <= '0;
      owner_valid <= 1'b0;
      lock_cnt <= '0;
      ack_o <= '0;
      rdata_o <= '0;
      busy_o <= 1'b0;
      mem_ce_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_width_o <= '0;
      mem_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (owner_valid && !lock_i[owner]) begin
            owner_valid <= 1'b0;
            lock_cnt <= '0;
          end
          if (found) begin
            state <= ISSUE;
            win <= pick;
            busy_o <= 1'b1;
            mem_ce_o <= 1'b1;
            mem_we_o <= we_i[pick];
            mem_addr_o <= addr_i[int'(pick)*ADDR_W +: ADDR_W];
            mem_width_o <= width_i[int'(pick)*4 +: 4];
            mem_data_o <= wdata_i[int'(pick)*DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          state <= RESP;
          mem_ce_o <= 1'b0;
          mem_we_o <= 1'b0;
          if (!mem_we_o) rdata_o <= mem_data_i;
          ack_o <= N_REQ'(1) << win;
        end
        RESP: begin
          state <= IDLE;
          busy_o <= 1'b0;
          ack_o <= '0;
          last <= win;
          if (lock_i[win] && lock_cnt < LW'(MAX_LOCK - 1)) begin
            owner_valid <= 1'b1;
            owner <= win;
            lock_cnt <= lock_cnt + 1'b1;
          end else begin
            owner_valid <= 1'b0;
            lock_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level reference
module tb_mem_arbiter;
  localparam int N = 4, AW = 32, DW = 32, ML = 8;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req = '0, lock = '0, we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*4-1:0] width = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0] ack;
  logic [DW-1:0] rdata, mem_rd, mem_wd;
  logic busy, ce, mwe;
  logic [AW-1:0] maddr;
  logic [3:0] mwidth;
  logic [N-1:0] req_b = '0, lock_b = '0, ack_b;
  logic [DW-1:0] rdata_b, data_b;
  logic busy_b, ce_b, we_b;
  logic [AW-1:0] addr_b;
  logic [3:0] width_b;
  logic [31:0] mem [0:255];
  int n_cmp = 0, n_err = 0;

  mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .we_i(we), .addr_i(addr), .width_i(width),
    .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .busy_o(busy), .mem_ce_o(ce), .mem_we_o(mwe),
    .mem_addr_o(maddr), .mem_width_o(mwidth), .mem_data_o(mem_wd), .mem_data_i(mem_rd));

  mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(2)) dut_b (
    .clk(clk), .rst(rst), .req_i(req_b), .lock_i(lock_b), .we_i('0), .addr_i('0), .width_i('0),
    .wdata_i('0), .ack_o(ack_b), .rdata_o(rdata_b), .busy_o(busy_b), .mem_ce_o(ce_b), .mem_we_o(we_b),
    .mem_addr_o(addr_b), .mem_width_o(width_b), .mem_data_o(data_b), .mem_data_i('0));

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int i);
    return i == 16 ? 32'hDEAD_BEEF : 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // backing sram: refilled with a known pattern while reset is held
  always @(posedge clk)
    if (!rst) for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    else if (ce && mwe) mem[maddr[9:2]] <= mem_wd;
  assign mem_rd = mem[maddr[9:2]];

  // reference: an access occupies three edges (grant, memory cycle, ack); -1 means none/no owner
  int g_who, g_age, m_last, m_owner, m_run, nxt;
  logic g_we;
  logic [AW-1:0] g_addr;
  logic [3:0] g_width;
  logic [DW-1:0] g_wdata, m_rdata;

  function automatic int choose(logic [N-1:0] r, int last_i, int own);
    if (own >= 0) return r[own] ? own : -1;
    for (int k = 1; k <= N; k++) if (r[(last_i + k) % N]) return (last_i + k) % N;
    return -1;
  endfunction

  always_comb nxt = choose(req, m_last, (m_owner >= 0 && lock[m_owner[1:0]]) ? m_owner : -1);

  always @(posedge clk or negedge rst)
    if (!rst) begin
      g_who <= -1; g_age <= 0; m_last <= N - 1; m_owner <= -1; m_run <= 0;
      g_we <= 1'b0; g_addr <= '0; g_width <= '0; g_wdata <= '0; m_rdata <= '0;
    end else if (g_who < 0) begin
      if (m_owner >= 0 && !lock[m_owner[1:0]]) begin m_owner <= -1; m_run <= 0; end
      if (nxt >= 0) begin
        g_who <= nxt; g_age <= 1; g_we <= we[nxt[1:0]];
        g_addr <= addr[nxt*AW +: AW]; g_width <= width[nxt*4 +: 4]; g_wdata <= wdata[nxt*DW +: DW];
      end
    end else if (g_age == 1) begin
      g_age <= 2;
      if (!g_we) m_rdata <= mem[g_addr[9:2]];
    end else begin
      g_who <= -1; m_last <= g_who;
      if (lock[g_who[1:0]] && m_run < ML - 1) begin m_owner <= g_who; m_run <= m_run + 1; end
      else begin m_owner <= -1; m_run <= 0; end
    end

  task automatic do_reset();
    rst = 1'b0; req = '0; lock = '0; we = '0; addr = '0; width = '0; wdata = '0; req_b = '0; lock_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (ack !== 4'b0) begin n_err++; $display("FAIL reset_ack: got %b exp 0000", ack); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL reset_ce: got %b exp 0", ce); end
    n_cmp++; if (mwe !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b exp 0", mwe); end
    n_cmp++; if (maddr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h exp 0", maddr); end
    n_cmp++; if (mwidth !== 4'h0) begin n_err++; $display("FAIL reset_width: got %h exp 0", mwidth); end
    n_cmp++; if (mem_wd !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h exp 0", mem_wd); end
    n_cmp++; if ({ack_b, busy_b, ce_b, we_b, width_b} !== 11'h0 || {rdata_b, data_b, addr_b} !== 96'h0) begin
      n_err++; $display("FAIL reset_b: got ack=%b busy=%b ce=%b we=%b w=%h rd=%h d=%h a=%h exp all 0",
                        ack_b, busy_b, ce_b, we_b, width_b, rdata_b, data_b, addr_b);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    req[1] = 1'b1; addr[AW +: AW] = 32'h40;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (ce !== 1'b1) begin n_err++; $display("FAIL rd_ce: got %b exp 1", ce); end
    n_cmp++; if (maddr !== 32'h40) begin n_err++; $display("FAIL rd_addr: got %h exp 40", maddr); end
    n_cmp++; if (mwe !== 1'b0) begin n_err++; $display("FAIL rd_we: got %b exp 0", mwe); end
    n_cmp++; if (ack !== 4'b0) begin n_err++; $display("FAIL rd_early_ack: got %b exp 0000", ack); end
    @(negedge clk);
    n_cmp++; if (ack !== 4'b0010) begin n_err++; $display("FAIL rd_ack: got %b exp 0010", ack); end
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data: got %h exp deadbeef", rdata); end
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL rd_ce_off: got %b exp 0", ce); end
    req[1] = 1'b0;
    @(negedge clk);
    n_cmp++; if (ack !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rd_done: got ack=%b busy=%b exp 0000/0", ack, busy); end
  endtask

  task automatic test_round_robin();
    int who[$], tm[$];
    int idx;
    do_reset();
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = 32'(i * 4);
    req = '1;
    for (int c = 0; c < 40 && who.size() < 8; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (ack[i]) idx = i;
        n_cmp++; if (!$onehot(ack)) begin n_err++; $display("FAIL rr_onehot: got %b exp one-hot", ack); end
        n_cmp++; if (rdata !== pat(idx)) begin n_err++; $display("FAIL rr_rdata: got %h exp %h", rdata, pat(idx)); end
        who.push_back(idx); tm.push_back(c);
      end
    end
    req = '0;
    n_cmp++; if (who.size() != 8) begin n_err++; $display("FAIL rr_count: got %0d exp 8", who.size()); end
    for (int k = 0; k < who.size(); k++) begin
      n_cmp++; if (who[k] != k % N) begin n_err++; $display("FAIL rr_order[%0d]: got %0d exp %0d", k, who[k], k % N); end
      if (k > 0) begin
        n_cmp++; if (tm[k] - tm[k-1] != 3) begin n_err++; $display("FAIL rr_spacing[%0d]: got %0d exp 3", k, tm[k] - tm[k-1]); end
      end
    end
    if (tm.size() > 4) begin
      n_cmp++; if (tm[4] - tm[0] != 12) begin n_err++; $display("FAIL rr_round: got %0d exp 12", tm[4] - tm[0]); end
    end
  endtask

  task automatic test_locked_burst();
    int order[$];
    int n2;
    n2 = 0;
    do_reset();
    req[2] = 1'b1; lock[2] = 1'b1; addr[2*AW +: AW] = 32'h80;
    @(negedge clk);
    req[0] = 1'b1; addr[0 +: AW] = 32'h20;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      if (ack[2]) begin
        order.push_back(2);
        n_cmp++; if (rdata !== pat(32 + n2)) begin n_err++; $display("FAIL lk_rdata%0d: got %h exp %h", n2, rdata, pat(32 + n2)); end
        n2++;
        if (n2 < 3) addr[2*AW +: AW] = 32'h80 + 32'(4 * n2);
        else begin req[2] = 1'b0; lock[2] = 1'b0; end
      end
      if (ack[0]) begin
        order.push_back(0);
        n_cmp++; if (rdata !== pat(8)) begin n_err++; $display("FAIL lk_rdata_r0: got %h exp %h", rdata, pat(8)); end
        req[0] = 1'b0;
      end
    end
    n_cmp++; if (order.size() != 4) begin n_err++; $display("FAIL lk_count: got %0d exp 4", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      n_cmp++; if (order[k] != (k < 3 ? 2 : 0)) begin n_err++; $display("FAIL lk_order[%0d]: got %0d exp %0d", k, order[k], k < 3 ? 2 : 0); end
    end
  endtask

  task automatic test_max_lock();
    int order[$];
    int exp_b [4] = '{3, 3, 1, 3};
    do_reset();
    req_b[3] = 1'b1; lock_b[3] = 1'b1;
    @(negedge clk);
    req_b[1] = 1'b1;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (ack_b[i]) order.push_back(i);
      if (ack_b[1]) req_b[1] = 1'b0;
    end
    req_b = '0; lock_b = '0;
    n_cmp++; if (order.size() != 4) begin n_err++; $display("FAIL ml_count: got %0d exp 4", order.size()); end
    for (int k = 0; k < order.size() && k < 4; k++) begin
      n_cmp++; if (order[k] != exp_b[k]) begin n_err++; $display("FAIL ml_order[%0d]: got %0d exp %0d", k, order[k], exp_b[k]); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] exp_rd [3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678};
    int nwe;
    logic seen;
    do_reset();
    for (int op = 0; op < 3; op++) begin
      nwe = 0; seen = 1'b0;
      req[0] = 1'b1; we[0] = (op == 1); addr[0 +: AW] = op == 0 ? 32'h40 : 32'h10;
      width[3:0] = 4'hF; wdata[0 +: DW] = 32'h1234_5678;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge clk);
        if (mwe) begin
          nwe++;
          n_cmp++; if ({ce, maddr, mwidth, mem_wd} !== {1'b1, 32'h10, 4'hF, 32'h1234_5678}) begin
            n_err++; $display("FAIL wr_issue: got ce=%b a=%h w=%h d=%h exp 1/10/f/12345678", ce, maddr, mwidth, mem_wd);
          end
        end
        seen = ack[0];
      end
      n_cmp++; if (!seen) begin n_err++; $display("FAIL wr_ack%0d: got no ack exp ack within 8 cycles", op); end
      n_cmp++; if (nwe != (op == 1 ? 1 : 0)) begin n_err++; $display("FAIL wr_we_cycles%0d: got %0d exp %0d", op, nwe, op == 1 ? 1 : 0); end
      n_cmp++; if (rdata !== exp_rd[op]) begin n_err++; $display("FAIL wr_rdata%0d: got %h exp %h", op, rdata, exp_rd[op]); end
    end
    req = '0; we = '0;
  endtask

  task automatic test_reset_mid_issue();
    logic seen;
    seen = 1'b0;
    do_reset();
    req[1] = 1'b1; addr[AW +: AW] = 32'h40;
    @(posedge clk);
    #2;
    n_cmp++; if (ce !== 1'b1) begin n_err++; $display("FAIL mid_in_issue: got ce=%b exp 1", ce); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({ce, busy, mwe, ack, rdata, maddr} !== 71'h0) begin
      n_err++; $display("FAIL mid_outputs: got ce=%b busy=%b we=%b ack=%b rd=%h a=%h exp all 0", ce, busy, mwe, ack, rdata, maddr);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (ack !== 4'b0) begin n_err++; $display("FAIL mid_no_ack: got %b exp 0000", ack); end
    end
    rst = 1'b1; req = 4'b0011; addr[0 +: AW] = 32'h20;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        seen = 1'b1;
        n_cmp++; if (ack !== 4'b0001) begin n_err++; $display("FAIL mid_first: got %b exp 0001", ack); end
      end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL mid_timeout: got no ack exp ack within 10 cycles"); end
    req = '0;
  endtask

  task automatic test_random(int cycles);
    logic [N-1:0] ea;
    logic ece;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      ece = g_who >= 0 && g_age == 1;
      ea = (g_who >= 0 && g_age == 2) ? 4'b0001 << g_who : 4'b0000;
      n_cmp++; if (ack !== ea) begin n_err++; $display("FAIL rnd_ack c=%0d: got %b exp %b", c, ack, ea); end
      n_cmp++; if (ce !== ece) begin n_err++; $display("FAIL rnd_ce c=%0d: got %b exp %b", c, ce, ece); end
      n_cmp++; if (mwe !== (ece && g_we)) begin n_err++; $display("FAIL rnd_we c=%0d: got %b exp %b", c, mwe, ece && g_we); end
      n_cmp++; if (busy !== (g_who >= 0)) begin n_err++; $display("FAIL rnd_busy c=%0d: got %b exp %b", c, busy, g_who >= 0); end
      n_cmp++; if ({maddr, mwidth, mem_wd} !== {g_addr, g_width, g_wdata}) begin
        n_err++; $display("FAIL rnd_fields c=%0d: got %h/%h/%h exp %h/%h/%h", c, maddr, mwidth, mem_wd, g_addr, g_width, g_wdata);
      end
      n_cmp++; if (rdata !== m_rdata) begin n_err++; $display("FAIL rnd_rdata c=%0d: got %h exp %h", c, rdata, m_rdata); end
      for (int i = 0; i < N; i++)
        if ((req[i] && ack[i]) || (!req[i] && $urandom_range(0, 3) == 0)) begin
          if (req[i] && $urandom_range(0, 1) == 0) begin
            req[i] = 1'b0; lock[i] = 1'b0;
          end else begin
            req[i] = 1'b1;
            we[i] = $urandom_range(0, 2) == 0;
            lock[i] = $urandom_range(0, 2) == 0;
            addr[i*AW +: AW] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            width[i*4 +: 4] = 4'($urandom);
            wdata[i*DW +: DW] = $urandom;
          end
        end
    end
    req = '0; lock = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish exp finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_locked_burst();
    test_max_lock();
    test_write_read();
    test_reset_mid_issue();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing the single `mem` port (and through it the `sram` backing store) between up to `N_REQ` requesters: packet processors, the table-reconfiguration path and the packet loader. Each requester runs a req/ack handshake. The arbiter serialises accesses into one-cycle `mem` transactions and returns read data with a registered ack. An optional per-requester lock keeps ownership for back-to-back accesses, for example when a processor walks a multi-word action entry.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: address width; matches `ADDR_BUS`.
- `DATA_W`, 32: data width; matches `DATA_BUS`.
- `MAX_LOCK`, 8: maximum consecutive grants to one locked owner, ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_i`  in  N_REQ  per-requester access request.
- `lock_i`  in  N_REQ  per-requester request to keep ownership after the current access.
- `we_i`  in  N_REQ  per-requester write enable; 0 = read.
- `addr_i`  in  N_REQ×ADDR_W  per-requester address.
- `width_i`  in  N_REQ×4  per-requester byte-lane width code, passed through unchanged.
- `wdata_i`  in  N_REQ×DATA_W  per-requester write data.
- `ack_o`  out  N_REQ  one-cycle completion pulse to the served requester.
- `rdata_o`  out  DATA_W  read data, shared by all requesters, valid when `ack_o` pulses for a read.
- `busy_o`  out  1  high in ISSUE and RESP.
- `mem_ce_o`  out  1  mem chip enable.
- `mem_we_o`  out  1  mem write enable.
- `mem_addr_o`  out  ADDR_W  mem address.
- `mem_width_o`  out  4  mem width code.
- `mem_data_o`  out  DATA_W  mem write data.
- `mem_data_i`  in  DATA_W  mem read data, combinationally valid while `mem_ce_o` is high.

## Operation
- **Requester contract**
  - Hold `req_i`, `we_i`, `addr_i`, `width_i` and `wdata_i` stable from assertion until `ack_o`.
  - On the edge that ends the ack cycle, either drop `req_i` or present the next request.
- **FSM states:** IDLE, ISSUE, RESP.
- **IDLE**
  - Evaluate the candidates.
  - If any candidate is requesting, register the winner index, its `we`, `addr`, `width` and `wdata`, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - Drive `mem_ce_o=1` and the registered fields onto the `mem_*` outputs for exactly one cycle.
  - For a read, capture `mem_data_i` into `rdata_o` at the end of the cycle.
  - For a write, `rdata_o` holds its previous value.
  - Go to RESP.
- **RESP**
  - `ack_o[winner]=1`; all other `ack_o` bits are 0.
  - `mem_ce_o=0`.
  - Update priority and lock state, then go to IDLE unconditionally.
- **Round-robin**
  - Pointer `last` holds the last served index.
  - Search order is `last+1` … `N_REQ-1`, `0` … `last`, with modulo wrap.
  - `last` is updated in RESP.
- **Lock**
  - In RESP, if `lock_i[winner]=1` and `lock_cnt < MAX_LOCK-1`: `owner_valid=1`, `owner=winner`, `lock_cnt++`.
  - Otherwise: `owner_valid=0`, `lock_cnt=0`.
  - While `owner_valid=1`, the only candidate in IDLE is `req_i[owner]`. Other requesters wait even if the owner is idle.
  - If the owner drops `lock_i` while in IDLE, release immediately (`owner_valid=0`, `lock_cnt=0`) and arbitrate normally in the same cycle.
- **Fairness bound:** a locked owner gets at most `MAX_LOCK` consecutive grants. After a forced release, the search starts at `owner+1`.
- **Idle outputs:** the `mem_*` outputs other than `mem_ce_o` hold their last registered values. `mem_we_o` is gated to 0 whenever `mem_ce_o=0`.

## Timing
- **Reset values (while `rst`=0):**
  - `mem_ce_o`, `mem_we_o`, `mem_addr_o`, `mem_width_o`, `mem_data_o`, `ack_o`, `rdata_o`, `busy_o` = 0.
  - FSM = IDLE; `last` = `N_REQ-1`, so requester 0 has first priority; `owner_valid` = 0; `lock_cnt` = 0.
- **Reset mid-transaction:** reset in ISSUE or RESP aborts immediately. No ack is issued, and the interrupted access is not replayed. A write already presented to `mem` may or may not have completed.
- **Latency:** with `req_i` rising before edge E0, the sequence is:
  - IDLE samples the request at E0.
  - ISSUE runs during cycle E0..E1.
  - `ack_o` and `rdata_o` are valid during cycle E1..E2.
- **Throughput:** 3 cycles per access, whether locked or not.
- **Simultaneous requests:** resolved purely by the round-robin order above; the lowest index does not win by default.
- **`rdata_o`:** holds its value until the next read completes.
- **Invalid input:** `req_i` deasserted before ack is a protocol violation. The arbiter still completes the access and acks.

## Test plan
- **Single read:** requester 1 reads addr 0x40 holding 0xDEADBEEF → `mem_ce_o` high for 1 cycle with addr 0x40; `ack_o=4'b0010` two cycles after the sampling edge; `rdata_o=0xDEADBEEF`.
- **All four request together after reset:** grant order 0,1,2,3; each requester re-requests immediately after its ack → order continues 0,1,2,3; 12 cycles per round.
- **Locked burst:** requester 2 holds `lock_i` for 3 reads (0x80, 0x84, 0x88) while requester 0 also requests → all three requester-2 acks come before requester 0's ack.
- **MAX_LOCK=2:** requester 3 keeps `lock_i` and `req_i` high; requester 1 is pending → requester 3 gets 2 grants, then requester 1 is served, then requester 3 again.
- **Write then read:** requester 0 writes 0x12345678 to 0x10 with width 4'b1111, then reads 0x10 → `mem_we_o=1` only during the write's ISSUE cycle; read returns 0x12345678; `rdata_o` is unchanged by the write.
- **Reset mid-ISSUE:** `rst` pulled low during ISSUE → all outputs go to 0 immediately; no `ack_o`; after release, requester 0 has first priority.
